// File: rtl/exe_ctrl_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
package exe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned PC_IDX = 15;

  // EXE/MEM result is younger than MEM/WB, so it wins; the PC is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                         input logic is_pc);
    if (is_pc) return FWD_REG;
    if (ex_hit) return FWD_EXE;
    if (mem_hit) return FWD_MEM;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/exe_hazard_ctrl_hazard_detect.sv
// Combinational compare of the ID source indices against the EXE and MEM destinations.
module hazard_detect #(
  parameter int unsigned REG_W = 4
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_wb,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb,
  output logic             ex_hit_rn,
  output logic             ex_hit_rm,
  output logic             mem_hit_rn,
  output logic             mem_hit_rm
);

  assign ex_hit_rn  = id_valid & ex_wb & (id_src1 == ex_dest);
  assign ex_hit_rm  = id_valid & id_two_src & ex_wb & (id_src2 == ex_dest);
  assign mem_hit_rn = id_valid & mem_wb & (id_src1 == mem_dest);
  assign mem_hit_rm = id_valid & id_two_src & mem_wb & (id_src2 == mem_dest);

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Execute-stage pipeline controller: RAW hazards, stall/flush FSM, forwarding selects, NZCV.
// Build option EXE_FORWARD_EN enables operand forwarding; without it every hazard stalls.
module exe_hazard_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 4,
  parameter int unsigned ST_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  input  logic             id_s,
  input  logic             id_branch,
  input  logic [REG_W-1:0] id_dest,
  input  logic [ST_W-1:0]  alu_status,
  output logic             freeze,
  output logic             exe_bubble,
  output logic             flush,
  output logic [1:0]       sel_rn,
  output logic [1:0]       sel_rm,
  output logic [ST_W-1:0]  status_q
);

  state_e           state_q, state_d;
  logic [REG_W-1:0] ex_dest, mem_dest;
  logic             ex_wb, ex_mrd, ex_s, mem_wb;
  logic             ex_hit_rn, ex_hit_rm, mem_hit_rn, mem_hit_rm;
  logic             ex_hit, mem_hit, load_use, stall;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .id_valid   (id_valid),
    .id_src1    (id_src1),
    .id_src2    (id_src2),
    .id_two_src (id_two_src),
    .ex_dest    (ex_dest),
    .ex_wb      (ex_wb),
    .mem_dest   (mem_dest),
    .mem_wb     (mem_wb),
    .ex_hit_rn  (ex_hit_rn),
    .ex_hit_rm  (ex_hit_rm),
    .mem_hit_rn (mem_hit_rn),
    .mem_hit_rm (mem_hit_rm)
  );

  assign ex_hit   = ex_hit_rn | ex_hit_rm;
  assign mem_hit  = mem_hit_rn | mem_hit_rm;
  assign load_use = ex_hit & ex_mrd;

`ifdef EXE_FORWARD_EN
  assign stall = load_use;
`else
  // Without forwarding any pending writer blocks the read; load_use is a subset.
  assign stall = load_use | ex_hit | mem_hit;
`endif

  always_comb begin
    state_d    = state_q;
    freeze     = 1'b0;
    exe_bubble = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (stall) begin
          freeze     = 1'b1;
          exe_bubble = 1'b1;
`ifdef EXE_FORWARD_EN
          state_d    = STALL;
`endif
        end else if (id_valid && id_branch) begin
          state_d = FLUSH;
        end
      end
      // The held ID instruction may be a branch that was waiting on the load.
      STALL: state_d = (id_valid && id_branch) ? FLUSH : RUN;
      FLUSH: begin
        flush      = 1'b1;
        exe_bubble = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      ex_dest  <= '0;
      ex_wb    <= 1'b0;
      ex_mrd   <= 1'b0;
      ex_s     <= 1'b0;
      mem_dest <= '0;
      mem_wb   <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      mem_dest <= ex_dest;
      mem_wb   <= ex_wb;
      ex_dest  <= id_dest;
      if (exe_bubble) begin
        ex_wb  <= 1'b0;
        ex_mrd <= 1'b0;
        ex_s   <= 1'b0;
      end else begin
        ex_wb  <= id_valid & id_wb_en;
        ex_mrd <= id_valid & id_mem_read;
        ex_s   <= id_valid & id_s;
      end
      if (ex_s) status_q <= alu_status;
    end
  end

`ifdef EXE_FORWARD_EN
  localparam logic [REG_W-1:0] PcIdx = REG_W'(PC_IDX);

  logic [1:0] sel_rn_q, sel_rm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_rn_q <= FWD_REG;
      sel_rm_q <= FWD_REG;
    end else if (exe_bubble) begin
      sel_rn_q <= FWD_REG;
      sel_rm_q <= FWD_REG;
    end else begin
      sel_rn_q <= fwd_sel(ex_hit_rn, mem_hit_rn, id_src1 == PcIdx);
      sel_rm_q <= fwd_sel(ex_hit_rm, mem_hit_rm, id_src2 == PcIdx);
    end
  end

  assign sel_rn = sel_rn_q;
  assign sel_rm = sel_rm_q;
`else
  assign sel_rn = FWD_REG;
  assign sel_rm = FWD_REG;
`endif

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Bench for exe_hazard_ctrl: directed cycle tables plus random stimulus against a queue model.
module tb_exe_hazard_ctrl;

`ifdef EXE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic       rst, v;
    logic [3:0] s1, s2;
    logic       two, wb, mrd, s, br;
    logic [3:0] dest, alu;
  } in_t;

  typedef struct packed {
    logic       frz, bub, fl;
    logic [1:0] srn, srm;
    logic [3:0] st;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  typedef struct packed {
    logic       wb, mrd, s;
    logic [3:0] dest;
  } ins_t;

  logic       clk, rst, id_valid, id_two_src, id_wb_en, id_mem_read, id_s, id_branch;
  logic [3:0] id_src1, id_src2, id_dest, alu_status, status_q;
  logic       freeze, exe_bubble, flush;
  logic [1:0] sel_rn, sel_rm;

  int n_checks = 0;
  int n_errors = 0;

  exe_hazard_ctrl #(
    .REG_W (4),
    .ST_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .id_wb_en    (id_wb_en),
    .id_mem_read (id_mem_read),
    .id_s        (id_s),
    .id_branch   (id_branch),
    .id_dest     (id_dest),
    .alu_status  (alu_status),
    .freeze      (freeze),
    .exe_bubble  (exe_bubble),
    .flush       (flush),
    .sel_rn      (sel_rn),
    .sel_rm      (sel_rm),
    .status_q    (status_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the last two issued instructions, youngest at the back (EXE).
  ins_t       pipe[$];
  bit         m_flush, m_after_stall;
  logic [3:0] m_status;
  logic [1:0] m_srn, m_srm;

  function automatic in_t mk(input logic r, input logic v, input logic [3:0] s1,
                             input logic [3:0] s2, input logic two, input logic wb,
                             input logic mrd, input logic s, input logic br,
                             input logic [3:0] dest, input logic [3:0] alu);
    in_t t;
    t = '{rst: r, v: v, s1: s1, s2: s2, two: two, wb: wb, mrd: mrd, s: s, br: br,
          dest: dest, alu: alu};
    return t;
  endfunction

  function automatic out_t ex(input logic frz, input logic bub, input logic fl,
                              input logic [1:0] srn, input logic [1:0] srm,
                              input logic [3:0] st);
    out_t t;
    t = '{frz: frz, bub: bub, fl: fl, srn: srn, srm: srm, st: st};
    return t;
  endfunction

  // 0 when EXE writes r, 1 when only MEM does, -1 when nobody in flight does.
  function automatic int age_of(input logic [3:0] r);
    for (int k = 0; k < 2; k++) begin
      if (pipe[1-k].wb && pipe[1-k].dest == r) return k;
    end
    return -1;
  endfunction

  function automatic logic [1:0] pick(input int age, input logic [3:0] r);
    if (r == 4'd15) return 2'b00;
    if (age == 0) return 2'b01;
    if (age == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    pipe.delete();
    pipe.push_back('0);
    pipe.push_back('0);
    m_flush       = 1'b0;
    m_after_stall = 1'b0;
    m_status      = '0;
    m_srn         = '0;
    m_srm         = '0;
  endtask

  task automatic model_eval(input in_t i, output out_t o, output int a_rn, output int a_rm);
    bit stall;
    a_rn = i.v ? age_of(i.s1) : -1;
    a_rm = (i.v && i.two) ? age_of(i.s2) : -1;
    if (FWD) stall = !m_flush && !m_after_stall && (a_rn == 0 || a_rm == 0) && pipe[1].mrd;
    else     stall = !m_flush && (a_rn >= 0 || a_rm >= 0);
    o.frz = stall;
    o.bub = stall || m_flush;
    o.fl  = m_flush;
    o.srn = m_srn;
    o.srm = m_srm;
    o.st  = m_status;
  endtask

  task automatic model_clock(input in_t i);
    out_t o;
    int   a_rn, a_rm;
    ins_t issued;
    if (i.rst) begin
      model_reset();
      return;
    end
    model_eval(i, o, a_rn, a_rm);
    if (pipe[1].s) m_status = i.alu;
    m_after_stall = FWD && o.frz;
    m_flush       = !m_flush && !o.frz && i.v && i.br;
    if (FWD && !o.bub) begin
      m_srn = pick(a_rn, i.s1);
      m_srm = pick(a_rm, i.s2);
    end else begin
      m_srn = 2'b00;
      m_srm = 2'b00;
    end
    issued = o.bub ? ins_t'(0) : '{wb: i.v & i.wb, mrd: i.v & i.mrd, s: i.v & i.s,
                                   dest: i.dest};
    pipe.push_back(issued);
    void'(pipe.pop_front());
  endtask

  task automatic drive(input in_t i);
    rst         = i.rst;
    id_valid    = i.v;
    id_src1     = i.s1;
    id_src2     = i.s2;
    id_two_src  = i.two;
    id_wb_en    = i.wb;
    id_mem_read = i.mrd;
    id_s        = i.s;
    id_branch   = i.br;
    id_dest     = i.dest;
    alu_status  = i.alu;
  endtask

  function automatic out_t sample();
    out_t a;
    a = '{frz: freeze, bub: exe_bubble, fl: flush, srn: sel_rn, srm: sel_rm, st: status_q};
    return a;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got frz=%b bub=%b fl=%b rn=%b rm=%b st=%b, want frz=%b bub=%b fl=%b rn=%b rm=%b st=%b",
               name, act.frz, act.bub, act.fl, act.srn, act.srm, act.st,
               exp.frz, exp.bub, exp.fl, exp.srn, exp.srm, exp.st);
    end
  endtask

  // One cycle: apply inputs after the edge, sample at the falling edge, then clock.
  task automatic step(input in_t i, output out_t act);
    drive(i);
    @(negedge clk);
    act = sample();
    model_clock(i);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  in_t  nop;

  initial begin
    out_t act, exp_o;
    in_t  ri;
    int   a_rn, a_rm;

    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset landing on a FLUSH cycle.
`ifdef EXE_FORWARD_EN
    tbl.push_back('{mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 4'b0110), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 1, 1, 1, 0, 4'b0110)});
    tbl.push_back('{nop, ex(0, 0, 0, 0, 0, 0)});
    // ADD R1; SUB R2,R1,R3 -> EXE forward. Then with a gap -> MEM forward.
    tbl.push_back('{mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 1, 3, 1, 1, 0, 0, 0, 2, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{nop, ex(0, 0, 0, 1, 0, 0)});
    tbl.push_back('{mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{nop, ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 1, 3, 1, 1, 0, 0, 0, 2, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{nop, ex(0, 0, 0, 2, 0, 0)});
    // LDR R4; ADD R5,R4,R4 -> one stall, then both from MEM.
    tbl.push_back('{mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 4, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 4, 4, 1, 1, 0, 0, 0, 5, 0), ex(1, 1, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 4, 4, 1, 1, 0, 0, 0, 5, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{nop, ex(0, 0, 0, 2, 2, 0)});
    // LDR R6; B reading R6 -> stall, then flush.
    tbl.push_back('{mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 6, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 6, 0, 0, 0, 0, 0, 1, 0, 0), ex(1, 1, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 6, 0, 0, 0, 0, 0, 1, 0, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{nop, ex(0, 1, 1, 2, 0, 0)});
    tbl.push_back('{nop, ex(0, 0, 0, 0, 0, 0)});
`else
    tbl.push_back('{mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0110), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 1, 1, 0, 0, 4'b0110)});
    tbl.push_back('{nop, ex(0, 0, 0, 0, 0, 0)});
    // ADD R1; ORR R2,R1,R0 -> two stall cycles.
    tbl.push_back('{mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 2, 0), ex(1, 1, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 2, 0), ex(1, 1, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 2, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{nop, ex(0, 0, 0, 0, 0, 0)});
    // LDR R6; B reading R6 -> two stalls, then flush.
    tbl.push_back('{mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 6, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 6, 0, 0, 0, 0, 0, 1, 0, 0), ex(1, 1, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 6, 0, 0, 0, 0, 0, 1, 0, 0), ex(1, 1, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 6, 0, 0, 0, 0, 0, 1, 0, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{nop, ex(0, 1, 1, 0, 0, 0)});
    tbl.push_back('{nop, ex(0, 0, 0, 0, 0, 0)});
`endif
    // CMP sets NZCV=0100; the following ADD (s=0) leaves it alone.
    tbl.push_back('{mk(0, 1, 1, 2, 1, 0, 0, 1, 0, 0, 0), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 7, 4'b0100), ex(0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000), ex(0, 0, 0, 0, 0, 4'b0100)});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111), ex(0, 0, 0, 0, 0, 4'b0100)});

    foreach (tbl[k]) begin
      step(tbl[k].i, act);
      check($sformatf("row%0d", k), act, tbl[k].e);
    end

    // Random traffic against the model, with occasional resets.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), act);
    for (int n = 0; n < 600; n++) begin
      ri.rst  = ($urandom_range(0, 99) < 2);
      ri.v    = ($urandom_range(0, 9) < 8);
      ri.s1   = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      ri.s2   = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      ri.two  = 1'($urandom_range(0, 1));
      ri.wb   = ($urandom_range(0, 9) < 7);
      ri.mrd  = ($urandom_range(0, 9) < 3);
      ri.s    = ($urandom_range(0, 9) < 3);
      ri.br   = ($urandom_range(0, 9) < 1);
      ri.dest = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      ri.alu  = 4'($urandom);
      drive(ri);
      @(negedge clk);
      act = sample();
      model_eval(ri, exp_o, a_rn, a_rm);
      check($sformatf("rand%0d", n), act, exp_o);
      n_checks++;
      if (act.frz && act.fl) begin
        n_errors++;
        $display("FAIL rand%0d_excl: freeze=%b flush=%b, required not both 1", n, act.frz,
                 act.fl);
      end
      model_clock(ri);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
